// File: rtl/poly_unload_ctrl_bram.sv
// Polynomial BRAM unload controller: sweeps 52/64 words and streams them out through a credit-controlled FIFO.
// Define POLY_UNLOAD_BRAM_OREG_EN when the BRAM output register is enabled (read latency 2 instead of 1).
module poly_unload_ctrl_bram #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pol_unload_coeff4x,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_address_relative,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              poly_unload_done
);

`ifdef POLY_UNLOAD_BRAM_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = LAT + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, last_addr;
  logic [LAT-1:0]    rd_pipe;
  logic [DATA_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  fifo_count, inflight;
  logic              issue, capture, pop, accept_start;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + CNT_W'(rd_pipe[i]);
  end

  assign capture      = rd_pipe[LAT-1];
  assign out_valid    = (fifo_count != '0);
  assign pop          = out_valid && out_ready;
  assign accept_start = start && (state == S_IDLE || state == S_DONE);
  // Credit: a slot freed by this cycle's pop may be reused by this cycle's read.
  assign issue        = (state == S_READ) &&
                        ((fifo_count + inflight) < (CNT_W'(DEPTH) + CNT_W'(pop)));

  // NOTE: next state gets its default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_READ;
      S_READ:  if (issue && addr == last_addr) state_nxt = S_DRAIN;
      S_DRAIN: if (inflight == '0 && fifo_count == CNT_W'(pop)) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_READ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      last_addr  <= '0;
      rd_pipe    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept_start) begin
        addr      <= '0;
        last_addr <= pol_unload_coeff4x ? ADDR_W'(63) : ADDR_W'(51);
      end else if (issue && addr != last_addr) begin
        addr <= addr + 1'b1;
      end
      rd_pipe[0] <= issue;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (capture) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      fifo_count <= fifo_count + CNT_W'(capture) - CNT_W'(pop);
    end
  end

  // NOTE: FIFO storage is not reset; out_data is masked while empty instead.
  always_ff @(posedge clk) begin
    if (capture) fifo_mem[wr_ptr] <= bram_dout;
  end

  assign bram_en               = issue;
  assign bram_address_relative = addr;
  assign out_data              = out_valid ? fifo_mem[rd_ptr] : '0;
  assign busy                  = (state == S_READ) || (state == S_DRAIN);
  assign poly_unload_done      = (state == S_DONE);

endmodule
